// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - sequential radix-2 Booth signed multiplier
module booth_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   c
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH:0]       m_q, m_d;      // multiplicand, sign-extended by one bit
  logic [WIDTH:0]       acc_q, acc_d;  // one guard bit so -M of the most-negative value fits
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 q1_q, q1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   c_q, c_d;
  logic                 done_q, done_d;
  logic [WIDTH:0]       sum;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign c    = c_q;

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: capture on start, one Booth step per RUN cycle, publish in FINISH
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    done_d  = 1'b0;
    sum     = acc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = {a[WIDTH-1], a};
          acc_d   = '0;
          q_d     = b;
          q1_d    = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
        case ({q_q[0], q1_q})
          2'b01:   sum = acc_q + m_q;
          2'b10:   sum = acc_q - m_q;
          default: sum = acc_q;
        endcase
        // arithmetic right shift of {A, Q, Q_1}
        acc_d = {sum[WIDTH], sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        c_d     = {acc_q[WIDTH-1:0], q_q};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - scoreboard bench for booth_multiplier
module tb_booth_multiplier;

  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH + 1;

  typedef struct {
    logic [2*WIDTH-1:0] exp;
    int                 edge_no;
  } sb_entry_t;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   c;

  sb_entry_t            sb[$];
  int                   edge_cnt = 0;
  int                   n_vec    = 0;
  int                   n_miss   = 0;
  logic [2*WIDTH-1:0]   last_exp = '0;

  booth_multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .c     (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  // monitor: every done pulse must match the oldest outstanding operation
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_done: got done=1 c=%0d, required no done", $signed(c));
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        if (c !== e.exp) begin
          n_miss++;
          $display("FAIL product: got c=%0d, required %0d", $signed(c), $signed(e.exp));
        end
        n_vec++;
        if (edge_cnt - e.edge_no != LAT) begin
          n_miss++;
          $display("FAIL latency: got %0d edges, required %0d", edge_cnt - e.edge_no, LAT);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // drive a start pulse; only accepted starts are pushed to the scoreboard
  task automatic issue(input int av, input int bv, input int ex, input bit push_it);
    @(negedge clk);
    a     = WIDTH'(av);
    b     = WIDTH'(bv);
    start = 1'b1;
    if (push_it) begin
      sb.push_back('{exp: (2*WIDTH)'(ex), edge_no: edge_cnt + 1});
      last_exp = (2*WIDTH)'(ex);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int av, input int bv, input int ex);
    issue(av, bv, ex, 1'b1);
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * LAT; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_miss++;
      $display("FAIL %s: got no done within %0d cycles, required done", name, 4 * LAT);
    end
  endtask

  initial begin
    int av;
    int bv;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("reset_c", 32'(c), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // abort mid-operation
    issue(5, 7, 35, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_c", 32'(c), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_abort_c", 32'(c), 32'd0);
    run(1, 1, 1);

    // directed signed vectors
    run(-16, -16, 256);
    run(-107, 32, -3424);
    run(7, 0, 0);
    run(1, 1, 1);
    run(60, 5, 300);
    run(-86, 35, -3010);
    run(17, 28, 476);
    run(8, -65, -520);

    // extremes
    run(-128, -128, 16384);
    run(-128, 127, -16256);
    run(127, 127, 16129);
    run(-1, -1, 1);
    run(0, -128, 0);

    // start while busy is ignored
    issue(-37, 11, -407, 1'b1);
    repeat (2) @(negedge clk);
    issue(99, 99, 0, 1'b0);
    repeat (LAT) @(negedge clk);

    // operand changes during RUN have no effect
    issue(45, -3, -135, 1'b1);
    for (int i = 0; i < WIDTH; i++) begin
      a = WIDTH'(i * 37);
      b = WIDTH'(255 - i * 11);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // back-to-back: new start in the done cycle
    issue(-50, 50, -2500, 1'b1);
    wait_done("b2b_first");
    a     = WIDTH'(-9);
    b     = WIDTH'(-13);
    start = 1'b1;
    sb.push_back('{exp: 16'(117), edge_no: edge_cnt + 1});
    last_exp = 16'(117);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_second");

    // hold: c stable, done low
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_c", 32'(c), 32'(last_exp));
      check("hold_done", 32'(done), 32'd0);
    end

    // random signed pairs against a*b
    for (int i = 0; i < 300; i++) begin
      av = int'($urandom_range(0, 255)) - 128;
      bv = int'($urandom_range(0, 255)) - 128;
      run(av, bv, av * bv);
    end

    repeat (2 * LAT) @(negedge clk);
    check("drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
